// File: rtl/input_debouncer_if.sv
// -----------------------------------------------------------------------------
// input_debouncer_if
// Groups the raw-input / debounced-output signals of input_debouncer.
//   raw_in     : asynchronous raw level (switch, pin), driven by master
//   x_out      : debounced level, driven by the debouncer (slave)
//   armed      : high while a candidate level change is being qualified
//   glitch_cnt : saturating rejected-glitch count, only when the macro
//                DEBOUNCE_GLITCH_CNT_EN is defined
// Modports: master (the environment feeding raw_in), slave (the debouncer).
// -----------------------------------------------------------------------------
interface input_debouncer_if;
    logic       raw_in;
    logic       x_out;
    logic       armed;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;

    modport master (output raw_in, input x_out, input armed, input glitch_cnt);
    modport slave  (input raw_in, output x_out, output armed, output glitch_cnt);
`else
    modport master (output raw_in, input x_out, input armed);
    modport slave  (input raw_in, output x_out, output armed);
`endif
endinterface

// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
// Synchronises an asynchronous raw level into the clock domain and only
// accepts a new level after STABLE_CYCLES consecutive synchronised samples
// that differ from the current output. Feeds the toggle detector's x input.
//
// Ports:
//   clock      : single clock, rising edge
//   reset      : synchronous, active-high reset
//   bus.raw_in : asynchronous raw level
//   bus.x_out  : registered debounced level
//   bus.armed  : registered, high while in ARM_HIGH / ARM_LOW
//   bus.glitch_cnt : saturating (255) rejected-glitch count
//
// Optional feature macro: DEBOUNCE_GLITCH_CNT_EN (adds glitch_cnt).
// -----------------------------------------------------------------------------
module input_debouncer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic              clock,
    input  logic              reset,
    input_debouncer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        ARM_HIGH  = 2'd1,
        IDLE_HIGH = 2'd2,
        ARM_LOW   = 2'd3
    } state_t;

    // Counter value at which one more differing sample completes qualification.
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync_q;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_next;
    logic                   r_x_out;
    logic                   w_x_next;
    logic                   r_armed;
    logic                   w_armed_next;

    assign w_sync_q = r_sync[SYNC_STAGES-1];

    // Synchroniser chain: stage 0 samples raw_in, the top stage is sync_q.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.raw_in};
        end
    end

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic       w_glitch;
    logic [7:0] r_glitch_cnt;
`endif

    // Next-state / next-output logic.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
`ifdef DEBOUNCE_GLITCH_CNT_EN
        w_glitch     = 1'b0;
`endif
        case (r_state)
            IDLE_LOW: begin
                if (w_sync_q) begin
                    // With a one-sample window the first differing sample
                    // already qualifies, so ARM is skipped entirely.
                    if (STABLE_CYCLES == 1) begin
                        w_state_next = IDLE_HIGH;
                    end else begin
                        w_state_next = ARM_HIGH;
                        w_cnt_next   = CNT_W'(1);
                    end
                end
            end
            ARM_HIGH: begin
                if (w_sync_q) begin
                    if (r_cnt == STABLE_LAST) begin
                        w_state_next = IDLE_HIGH;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next   = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_state_next = IDLE_LOW;
                    w_cnt_next   = '0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
                    w_glitch     = 1'b1;
`endif
                end
            end
            IDLE_HIGH: begin
                if (!w_sync_q) begin
                    if (STABLE_CYCLES == 1) begin
                        w_state_next = IDLE_LOW;
                    end else begin
                        w_state_next = ARM_LOW;
                        w_cnt_next   = CNT_W'(1);
                    end
                end
            end
            ARM_LOW: begin
                if (!w_sync_q) begin
                    if (r_cnt == STABLE_LAST) begin
                        w_state_next = IDLE_LOW;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next   = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_state_next = IDLE_HIGH;
                    w_cnt_next   = '0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
                    w_glitch     = 1'b1;
`endif
                end
            end
            default: begin
                w_state_next = IDLE_LOW;
                w_cnt_next   = '0;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        w_x_next     = (w_state_next == IDLE_HIGH) || (w_state_next == ARM_LOW);
        w_armed_next = (w_state_next == ARM_HIGH)  || (w_state_next == ARM_LOW);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_x_out <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_x_out <= w_x_next;
            r_armed <= w_armed_next;
        end
    end

`ifdef DEBOUNCE_GLITCH_CNT_EN
    // Saturating count of rejected glitches; cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_glitch_cnt <= '0;
        end else if (w_glitch && (r_glitch_cnt != 8'hFF)) begin
            r_glitch_cnt <= r_glitch_cnt + 8'd1;
        end
    end

    assign bus.glitch_cnt = r_glitch_cnt;
`endif

    assign bus.x_out = r_x_out;
    assign bus.armed = r_armed;

endmodule

// File: tb/tb_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_input_debouncer
// Drives input_debouncer (default parameters) and a second instance with
// STABLE_CYCLES=1. The reference model tracks the synchroniser as a queue of
// raw samples and the debouncer as a run length of samples that differ from
// the current output level.
// -----------------------------------------------------------------------------
module tb_input_debouncer;

    localparam int SS = 2;
    localparam int SC = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic reset2 = 1'b1;
    logic g_raw2 = 1'b0;
    logic g_rst2 = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    input_debouncer_if bus1 ();
    input_debouncer_if bus2 ();

    input_debouncer #(.SYNC_STAGES(SS), .STABLE_CYCLES(SC), .CNT_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    input_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(1), .CNT_W(8)) dut1 (
        .clock (clock),
        .reset (reset2),
        .bus   (bus2)
    );

    // ---------------- reference model ----------------
    logic m_hist[$];
    logic m_x;
    int   m_run;
    logic m_armed;
    int   m_gcnt;

    task automatic model_edge(input logic raw, input logic rst);
        logic sq;
        if (rst) begin
            m_hist.delete();
            for (int i = 0; i < SS; i++) m_hist.push_back(1'b0);
            m_x = 1'b0; m_run = 0; m_gcnt = 0;
        end else begin
            sq = m_hist.pop_front();
            m_hist.push_back(raw);
            if (sq != m_x) begin
                m_run++;
                if (m_run == SC) begin
                    m_x   = ~m_x;
                    m_run = 0;
                end
            end else begin
                if (m_run > 0 && m_gcnt < 255) m_gcnt++;
                m_run = 0;
            end
        end
        m_armed = (m_run != 0);
    endtask

    // One clock: drive at negedge, update model at posedge, settle 1 time unit.
    task automatic tick(input logic raw, input logic rst);
        @(negedge clock);
        bus1.raw_in = raw;
        reset       = rst;
        bus2.raw_in = g_raw2;
        reset2      = g_rst2;
        @(posedge clock);
        model_edge(raw, rst);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1);
            n_checks++;
            if (bus1.x_out !== 1'b0) begin
                n_fail++; $display("FAIL reset_x_out cyc%0d: got %b want 0", i, bus1.x_out);
            end
            n_checks++;
            if (bus1.armed !== 1'b0) begin
                n_fail++; $display("FAIL reset_armed cyc%0d: got %b want 0", i, bus1.armed);
            end
`ifdef DEBOUNCE_GLITCH_CNT_EN
            n_checks++;
            if (bus1.glitch_cnt !== 8'd0) begin
                n_fail++; $display("FAIL reset_glitch_cnt cyc%0d: got %0d want 0", i, bus1.glitch_cnt);
            end
`endif
        end
        $display("test_reset done");
    endtask

    task automatic test_clean_rise();
        logic ex_x, ex_a;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        for (int e = 3; e <= 17; e++) begin
            tick(e >= 10, 1'b0);
            ex_a = (e >= 12) && (e < 15);
            ex_x = (e >= 15);
            n_checks++;
            if (bus1.x_out !== ex_x) begin
                n_fail++; $display("FAIL rise_x_out edge%0d: got %b want %b", e, bus1.x_out, ex_x);
            end
            n_checks++;
            if (bus1.armed !== ex_a) begin
                n_fail++; $display("FAIL rise_armed edge%0d: got %b want %b", e, bus1.armed, ex_a);
            end
        end
        $display("test_clean_rise done");
    endtask

    task automatic test_glitch();
        int armed_cycles = 0;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            tick(i < 3, 1'b0);
            if (bus1.armed === 1'b1) armed_cycles++;
            n_checks++;
            if (bus1.x_out !== 1'b0) begin
                n_fail++; $display("FAIL glitch_x_out cyc%0d: got %b want 0", i, bus1.x_out);
            end
        end
        n_checks++;
        if (armed_cycles != 3) begin
            n_fail++; $display("FAIL glitch_armed_len: got %0d want 3", armed_cycles);
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        n_checks++;
        if (bus1.glitch_cnt !== 8'd1) begin
            n_fail++; $display("FAIL glitch_cnt: got %0d want 1", bus1.glitch_cnt);
        end
`endif
        $display("test_glitch done armed_cycles=%0d", armed_cycles);
    endtask

    task automatic test_fall();
        int   falls = 0;
        logic prev, ex_x;
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
        n_checks++;
        if (bus1.x_out !== 1'b1) begin
            n_fail++; $display("FAIL fall_pre_high: got %b want 1", bus1.x_out);
        end
        prev = bus1.x_out;
        for (int i = 0; i < 9; i++) begin
            tick(1'b0, 1'b0);
            ex_x = (i < 5);
            if (prev === 1'b1 && bus1.x_out === 1'b0) falls++;
            prev = bus1.x_out;
            n_checks++;
            if (bus1.x_out !== ex_x) begin
                n_fail++; $display("FAIL fall_x_out k+%0d: got %b want %b", i, bus1.x_out, ex_x);
            end
        end
        n_checks++;
        if (falls != 1) begin
            n_fail++; $display("FAIL fall_edge_count: got %0d want 1", falls);
        end
        $display("test_fall done falls=%0d", falls);
    endtask

    task automatic test_reset_mid_arm();
        logic ex_x, ex_a;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);  // cnt reaches 2
        n_checks++;
        if (bus1.armed !== 1'b1) begin
            n_fail++; $display("FAIL midarm_armed_before: got %b want 1", bus1.armed);
        end
        tick(1'b1, 1'b1);
        n_checks++;
        if (bus1.x_out !== 1'b0 || bus1.armed !== 1'b0) begin
            n_fail++; $display("FAIL midarm_reset: got x=%b armed=%b want x=0 armed=0", bus1.x_out, bus1.armed);
        end
        for (int i = 0; i < 7; i++) begin
            tick(1'b1, 1'b0);
            ex_x = (i >= 5);
            ex_a = (i >= 2) && (i < 5);
            n_checks++;
            if (bus1.x_out !== ex_x || bus1.armed !== ex_a) begin
                n_fail++; $display("FAIL midarm_restart j+%0d: got x=%b armed=%b want x=%b armed=%b",
                                   i, bus1.x_out, bus1.armed, ex_x, ex_a);
            end
        end
        $display("test_reset_mid_arm done");
    endtask

    task automatic test_stable1();
        logic ex_x;
        g_rst2 = 1'b1; g_raw2 = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        g_rst2 = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        g_raw2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b0);
            ex_x = (i >= 2);
            n_checks++;
            if (bus2.x_out !== ex_x) begin
                n_fail++; $display("FAIL sc1_x_out k+%0d: got %b want %b", i, bus2.x_out, ex_x);
            end
            n_checks++;
            if (bus2.armed !== 1'b0) begin
                n_fail++; $display("FAIL sc1_armed k+%0d: got %b want 0", i, bus2.armed);
            end
        end
        g_raw2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0);
            ex_x = (i < 2);
            n_checks++;
            if (bus2.x_out !== ex_x || bus2.armed !== 1'b0) begin
                n_fail++; $display("FAIL sc1_fall k+%0d: got x=%b armed=%b want x=%b armed=0",
                                   i, bus2.x_out, bus2.armed, ex_x);
            end
        end
        g_rst2 = 1'b1;
        $display("test_stable1 done");
    endtask

    task automatic test_random();
        logic lvl = 1'b0;
        int   run = 0;
        int   bad = 0;
        logic rst;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            if (run == 0) begin
                lvl = ~lvl;
                run = $urandom_range(1, 7);
            end
            run--;
            rst = ($urandom_range(0, 249) == 0);
            tick(lvl, rst);
            n_checks++;
            if (bus1.x_out !== m_x || bus1.armed !== m_armed) begin
                n_fail++; bad++;
                if (bad <= 10)
                    $display("FAIL rand_out cyc%0d: got x=%b armed=%b want x=%b armed=%b",
                             i, bus1.x_out, bus1.armed, m_x, m_armed);
            end
`ifdef DEBOUNCE_GLITCH_CNT_EN
            n_checks++;
            if (bus1.glitch_cnt !== 8'(m_gcnt)) begin
                n_fail++; bad++;
                if (bad <= 10)
                    $display("FAIL rand_glitch_cnt cyc%0d: got %0d want %0d", i, bus1.glitch_cnt, m_gcnt);
            end
`endif
        end
        $display("test_random done errors=%0d", bad);
    endtask

`ifdef DEBOUNCE_GLITCH_CNT_EN
    task automatic test_saturation();
        int bad = 0;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        for (int p = 0; p < 300; p++) begin
            for (int c = 0; c < 5; c++) begin
                tick(c < 3, 1'b0);
                n_checks++;
                if (bus1.x_out !== 1'b0) begin
                    n_fail++; bad++;
                    if (bad <= 10) $display("FAIL sat_x_out pulse%0d: got %b want 0", p, bus1.x_out);
                end
            end
        end
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
        n_checks++;
        if (bus1.glitch_cnt !== 8'd255) begin
            n_fail++; $display("FAIL sat_glitch_cnt: got %0d want 255", bus1.glitch_cnt);
        end
        $display("test_saturation done glitch_cnt=%0d", bus1.glitch_cnt);
    endtask
`endif

    initial begin
        bus1.raw_in = 1'b0;
        bus2.raw_in = 1'b0;
        for (int i = 0; i < SS; i++) m_hist.push_back(1'b0);
        m_x = 1'b0; m_run = 0; m_armed = 1'b0; m_gcnt = 0;

        test_reset();
        test_clean_rise();
        test_glitch();
        test_fall();
        test_reset_mid_arm();
        test_stable1();
        test_random();
`ifdef DEBOUNCE_GLITCH_CNT_EN
        test_saturation();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
